// File: rtl/decod_n_seq_if.sv
// decod_n_seq_if
//   Bundles the request/response signals of the decod_n_seq decoder.
//   master: the requester. It drives en, in_valid, sel and scan_start,
//           and it sees in_ready, out, out_valid and busy.
//   slave : the decoder itself.
//   Parameter SEL_W (select width) must match the decoder's SEL_W.
//   OUT_W is always 1 << SEL_W.
interface decod_n_seq_if #(parameter int SEL_W = 3);
  localparam int OUT_W = 1 << SEL_W;

  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             scan_start;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             busy;

  modport master (
    output en, in_valid, sel, scan_start,
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  en, in_valid, sel, scan_start,
    output in_ready, out, out_valid, busy
  );
endinterface

// File: rtl/decod_n_seq.sv
// decod_n_seq
//   Registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready input
//   handshake and a self-timed SCAN mode. SCAN sweeps the hot bit once across
//   all outputs, holding each output for DWELL cycles.
//
// Ports
//   clk   : single clock; all state changes on the rising edge
//   rst_n : asynchronous, active-low reset
//   bus   : decod_n_seq_if.slave, carrying these signals:
//     en         - block enable. Low clears the output and aborts SCAN.
//     in_valid   - sel is valid this cycle.
//     in_ready   - combinational: high when a select can be accepted.
//     sel        - binary select.
//     scan_start - one-cycle request to start a sweep.
//     out        - registered one-hot output.
//     out_valid  - out holds a decoded select (HOLD state).
//     busy       - high while a sweep is running.
//
// Parameters
//   SEL_W : select width, legal range 1..6
//   DWELL : cycles each output stays hot during SCAN, must be >= 1
//
// Configuration macro
//   DECOD_ACTIVE_LOW_EN : when defined, out is driven one-cold (bitwise
//                         inverse), so the idle value is all ones.
module decod_n_seq #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  decod_n_seq_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] hot;
  logic             accept;

  // A scan request takes priority over a select in the same cycle. To make
  // that visible, in_ready is dropped while scan_start is high.
  assign bus.in_ready = bus.en && (state != ST_SCAN) && !bus.scan_start;
  assign accept       = bus.in_valid && bus.in_ready;

  // Main state register. The hot vector is kept active-high internally.
  // Once the last bit has dwelt its full time, the sweep ends in IDLE, so
  // bit 0 is never hot again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hot   <= '0;
    end else if (!bus.en) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hot   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (bus.scan_start) begin
            state <= ST_SCAN;
            cnt   <= '0;
            hot   <= OUT_W'(1);
          end else if (accept) begin
            state <= ST_HOLD;
            hot   <= OUT_W'(1) << bus.sel;
          end
        end
        ST_SCAN: begin
          if (cnt == CNT_W'(DWELL - 1)) begin
            cnt <= '0;
            if (hot[OUT_W-1]) begin
              state <= ST_IDLE;
              hot   <= '0;
            end else begin
              hot <= hot << 1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          hot   <= '0;
        end
      endcase
    end
  end

  assign bus.out_valid = (state == ST_HOLD);
  assign bus.busy      = (state == ST_SCAN);

`ifdef DECOD_ACTIVE_LOW_EN
  assign bus.out = ~hot;
`else
  assign bus.out = hot;
`endif
endmodule

// File: tb/tb_decod_n_seq.sv
// tb_decod_n_seq
//   Directed and randomized bench for decod_n_seq (SEL_W=3, DWELL=4).
//   The expected outputs come from a mode/elapsed-cycle model: the hot bit
//   during a sweep is 1 << (cycles since start / DWELL).
module tb_decod_n_seq;
  localparam int SEL_W = 3;
  localparam int DWELL = 4;
  localparam int OUT_W = 1 << SEL_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference model state. mMode is 0 = idle, 1 = holding mSel, 2 = sweeping.
  int mMode = 0;
  int mSel = 0;
  int mScanCycle = 0;

  decod_n_seq_if #(.SEL_W(SEL_W)) bus ();

  decod_n_seq #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] expOut();
    logic [OUT_W-1:0] v;
    v = '0;
    if (mMode == 1) v = OUT_W'(1) << mSel;
    else if (mMode == 2) v = OUT_W'(1) << (mScanCycle / DWELL);
`ifdef DECOD_ACTIVE_LOW_EN
    v = ~v;
`endif
    return v;
  endfunction

  task automatic applyStimulus(input logic e, input logic iv, input int s, input logic ss);
    bus.en = e;
    bus.in_valid = iv;
    bus.sel = SEL_W'(s);
    bus.scan_start = ss;
  endtask

  task automatic checkOutput(input string tag);
    logic expReady;
    expReady = bus.en && (mMode != 2) && !bus.scan_start;
    total++;
    assert (bus.out === expOut()) else begin
      bad++;
      $error("[TB] FAIL %s out observed=%h expected=%h", tag, bus.out, expOut());
    end
    total++;
    assert (bus.out_valid === (mMode == 1)) else begin
      bad++;
      $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, bus.out_valid, mMode == 1);
    end
    total++;
    assert (bus.busy === (mMode == 2)) else begin
      bad++;
      $error("[TB] FAIL %s busy observed=%b expected=%b", tag, bus.busy, mMode == 2);
    end
    total++;
    assert (bus.in_ready === expReady) else begin
      bad++;
      $error("[TB] FAIL %s in_ready observed=%b expected=%b", tag, bus.in_ready, expReady);
    end
  endtask

  // Advance the model by one clock edge, using the inputs present at the edge.
  task automatic modelEdge();
    if (!rst_n || !bus.en) begin
      mMode = 0;
    end else if (mMode == 2) begin
      mScanCycle++;
      if (mScanCycle == OUT_W * DWELL) mMode = 0;
    end else if (bus.scan_start) begin
      mMode = 2;
      mScanCycle = 0;
    end else if (bus.in_valid) begin
      mMode = 1;
      mSel = int'(bus.sel);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    $display("[TB] start");

    // 1: asynchronous reset applied mid-cycle, checked with no clock edge
    rst_n = 1'b1;
    tick("pre_reset");
    #2 rst_n = 1'b0;
    mMode = 0;
    #1 checkOutput("async_reset");
    tick("reset_held");
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    tick("after_reset");

    // 2: back-to-back accepts, each output appears one edge later
    for (int i = 0; i < OUT_W; i++) begin
      applyStimulus(1'b1, 1'b1, i, 1'b0);
      tick("accept_seq");
    end
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    tick("hold_keep");

    // 3: en low blocks the accept and clears out; en high then accepts
    applyStimulus(1'b0, 1'b1, 5, 1'b0);
    #1 checkOutput("en_low_ready");
    tick("en_low_clear");
    tick("en_low_stay");
    applyStimulus(1'b1, 1'b1, 5, 1'b0);
    tick("en_high_sel5");

    // 4: full sweep followed by idle
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    tick("scan_enter");
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    for (int i = 1; i <= OUT_W * DWELL; i++) tick("scan_sweep");
    tick("scan_idle");

    // 5: scan_start beats in_valid; en low aborts the sweep
    applyStimulus(1'b1, 1'b1, 3, 1'b1);
    #1 checkOutput("scan_vs_valid_ready");
    tick("scan_vs_valid");
    applyStimulus(1'b1, 1'b1, 3, 1'b0);
    for (int i = 1; i < 10; i++) tick("scan_ignore_valid");
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    tick("scan_restart_ignored");
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    tick("scan_abort");

    // 6: reset during a sweep, while out is 08
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    tick("scan2_enter");
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 3 * DWELL; i++) tick("scan2_run");
    #2 rst_n = 1'b0;
    mMode = 0;
    #1 checkOutput("scan_reset");
    tick("scan_reset_held");
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, OUT_W - 1)), $urandom_range(0, 19) == 0);
      #1 checkOutput("rand_ready");
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
